// File: rtl/tick_monitor.sv
// Checks the periodic one-cycle tick from the time base: measures each tick interval,
// tracks lock to FREQ_CLK/FREQ_WANTED, and flags early and missing ticks.
module tick_monitor #(
   parameter int FREQ_CLK    = 50000000,
   parameter int FREQ_WANTED = 20000,
   parameter int TOLERANCE   = 2,
   parameter int LOCK_COUNT  = 4,
   localparam int NB_TIC     = FREQ_CLK / FREQ_WANTED,
   localparam int W          = $clog2(NB_TIC + TOLERANCE + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick,
   output logic [W-1:0] period,
   output logic         period_valid,
   output logic         locked,
   output logic         early,
   output logic         missing,
   output logic [7:0]   err_count
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam logic [W-1:0]  MIN_P   = W'(NB_TIC - TOLERANCE);
   localparam logic [W-1:0]  TMO_CNT = W'(NB_TIC + TOLERANCE - 1);
   localparam logic [GW-1:0] LOCK_N  = GW'(LOCK_COUNT);

   typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  cnt_q, cnt_d;
   logic [GW-1:0] good_cnt_q, good_cnt_d;
   logic [W-1:0]  period_q, period_d;
   logic          period_valid_q, period_valid_d;
   logic          early_q, early_d;
   logic          missing_q, missing_d;
   logic [7:0]    err_count_q, err_count_d;
   logic [W-1:0]  interval;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      good_cnt_d     = good_cnt_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
      early_d        = 1'b0;
      missing_d      = 1'b0;
      err_count_d    = err_count_q;
      interval       = cnt_q + W'(1);

      case (state_q)
         IDLE: begin
            // The first tick only establishes the reference point; nothing is measured.
            cnt_d = '0;
            if (tick) begin
               state_d    = SYNC;
               good_cnt_d = '0;
            end
         end
         default: begin
            if (tick) begin
               cnt_d          = '0;
               period_d       = interval;
               period_valid_d = 1'b1;
               if (interval < MIN_P) begin
                  early_d    = 1'b1;
                  good_cnt_d = '0;
                  state_d    = SYNC;
               end else if (state_q == SYNC) begin
                  good_cnt_d = good_cnt_q + GW'(1);
                  if (good_cnt_q + GW'(1) == LOCK_N) state_d = LOCKED;
               end
            end else if (cnt_q == TMO_CNT) begin
               // Fires before any tick could be late, so a late tick is never reported.
               missing_d = 1'b1;
               cnt_d     = '0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + W'(1);
            end
         end
      endcase

      if ((early_d || missing_d) && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         good_cnt_q     <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         early_q        <= 1'b0;
         missing_q      <= 1'b0;
         err_count_q    <= 8'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         good_cnt_q     <= good_cnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         early_q        <= early_d;
         missing_q      <= missing_d;
         err_count_q    <= err_count_d;
      end
   end

   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign locked       = (state_q == LOCKED);
   assign early        = early_q;
   assign missing      = missing_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Bench for tick_monitor with NB_TIC=10, TOLERANCE=1, LOCK_COUNT=4.
module tb_tick_monitor;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         tick;
   logic [W-1:0] period;
   logic         period_valid;
   logic         locked;
   logic         early;
   logic         missing;
   logic [7:0]   err_count;

   int n_checks;
   int n_pass;
   int miss_seen;
   int exp_q[$];

   tick_monitor #(
      .FREQ_CLK(100), .FREQ_WANTED(10), .TOLERANCE(1), .LOCK_COUNT(4)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .period(period),
      .period_valid(period_valid), .locked(locked), .early(early),
      .missing(missing), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

   // One clock cycle: drive tick, sample after the edge, and retire scoreboard entries.
   task automatic cyc(input bit t);
      logic [W-1:0] e;
      tick = t;
      @(posedge clk);
      #1;
      if (missing === 1'b1) miss_seen++;
      if (period_valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected_pulse got period %0d want no period_valid", period);
         end else begin
            e = W'(exp_q.pop_front());
            if (period !== e) $display("FAIL sb_period got %0d want %0d", period, e);
            else n_pass++;
         end
      end
   endtask

   task automatic send(input int n, input bit push);
      for (int i = 0; i < n - 1; i++) cyc(1'b0);
      if (push) exp_q.push_back(n);
      cyc(1'b1);
   endtask

   task automatic check_drained(input string name);
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL %s_drain got %0d pending want 0", name, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      cyc(1'b1);
      cyc(1'b1);
      reset = 1'b0;
      n_checks++;
      if ({period, period_valid, locked, early, missing, err_count} !== '0)
         $display("FAIL reset_outputs got p=%0d pv=%0b l=%0b e=%0b m=%0b err=%0d want all 0",
                  period, period_valid, locked, early, missing, err_count);
      else n_pass++;
   endtask

   task automatic test_lock_in;
      for (int i = 0; i < 5; i++) cyc(1'b0);
      cyc(1'b1);
      n_checks++;
      if (period_valid !== 1'b0) $display("FAIL lock_ref_pv got %0b want 0", period_valid);
      else n_pass++;
      for (int k = 1; k <= 4; k++) begin
         send(10, 1'b1);
         n_checks++;
         if (locked !== (k == 4)) $display("FAIL lock_locked_%0d got %0b want %0b", k, locked, k == 4);
         else n_pass++;
      end
      n_checks++;
      if (err_count !== 8'd0) $display("FAIL lock_err got %0d want 0", err_count);
      else n_pass++;
      check_drained("lock");
   endtask

   task automatic test_tolerance;
      int m0;
      m0 = miss_seen;
      send(9, 1'b1);
      n_checks++;
      if (period !== 4'd9 || locked !== 1'b1 || early !== 1'b0)
         $display("FAIL tol_9 got p=%0d l=%0b e=%0b want p=9 l=1 e=0", period, locked, early);
      else n_pass++;
      send(11, 1'b1);
      n_checks++;
      if (period !== 4'd11 || locked !== 1'b1 || early !== 1'b0 || miss_seen != m0)
         $display("FAIL tol_11 got p=%0d l=%0b e=%0b miss=%0d want p=11 l=1 e=0 miss=0",
                  period, locked, early, miss_seen - m0);
      else n_pass++;
      check_drained("tol");
   endtask

   task automatic test_early;
      send(8, 1'b1);
      n_checks++;
      if (early !== 1'b1 || period !== 4'd8 || locked !== 1'b0 || err_count !== 8'd1)
         $display("FAIL early_tick got e=%0b p=%0d l=%0b err=%0d want e=1 p=8 l=0 err=1",
                  early, period, locked, err_count);
      else n_pass++;
      for (int k = 1; k <= 4; k++) begin
         send(10, 1'b1);
         n_checks++;
         if (locked !== (k == 4) || early !== 1'b0)
            $display("FAIL early_relock_%0d got l=%0b e=%0b want l=%0b e=0", k, locked, early, k == 4);
         else n_pass++;
      end
      check_drained("early");
   endtask

   task automatic test_missing;
      logic [7:0] err0;
      err0 = err_count;
      for (int i = 0; i < 10; i++) cyc(1'b0);
      n_checks++;
      if (missing !== 1'b0 || locked !== 1'b1)
         $display("FAIL miss_before got m=%0b l=%0b want m=0 l=1", missing, locked);
      else n_pass++;
      cyc(1'b0);
      n_checks++;
      if (missing !== 1'b1 || locked !== 1'b0 || err_count !== err0 + 8'd1)
         $display("FAIL miss_timeout got m=%0b l=%0b err=%0d want m=1 l=0 err=%0d",
                  missing, locked, err_count, err0 + 8'd1);
      else n_pass++;
      cyc(1'b0);
      n_checks++;
      if (missing !== 1'b0) $display("FAIL miss_pulse_width got %0b want 0", missing);
      else n_pass++;
      send(7, 1'b0);
      n_checks++;
      if (period_valid !== 1'b0) $display("FAIL miss_ref_pv got %0b want 0", period_valid);
      else n_pass++;
      send(10, 1'b1);
      n_checks++;
      if (period_valid !== 1'b1 || period !== 4'd10)
         $display("FAIL miss_resume got pv=%0b p=%0d want pv=1 p=10", period_valid, period);
      else n_pass++;
      check_drained("miss");
   endtask

   task automatic test_reset_mid;
      for (int k = 0; k < 3; k++) send(10, 1'b1);
      send(5, 1'b1);
      for (int k = 0; k < 4; k++) send(10, 1'b1);
      n_checks++;
      if (locked !== 1'b1 || err_count !== 8'd3)
         $display("FAIL rst_pre got l=%0b err=%0d want l=1 err=3", locked, err_count);
      else n_pass++;
      check_drained("rst_pre");
      reset = 1'b1;
      cyc(1'b1);
      reset = 1'b0;
      n_checks++;
      if ({period, period_valid, locked, early, missing, err_count} !== '0)
         $display("FAIL rst_mid got p=%0d pv=%0b l=%0b e=%0b m=%0b err=%0d want all 0",
                  period, period_valid, locked, early, missing, err_count);
      else n_pass++;
      send(4, 1'b0);
      n_checks++;
      if (period_valid !== 1'b0 || early !== 1'b0)
         $display("FAIL rst_tick_ignored got pv=%0b e=%0b want pv=0 e=0", period_valid, early);
      else n_pass++;
   endtask

   task automatic test_held_tick;
      logic [7:0] want_err;
      for (int k = 0; k < 4; k++) send(10, 1'b1);
      n_checks++;
      if (locked !== 1'b1 || err_count !== 8'd0)
         $display("FAIL held_lock got l=%0b err=%0d want l=1 err=0", locked, err_count);
      else n_pass++;
      for (int i = 0; i < 9; i++) cyc(1'b0);
      for (int i = 0; i < 300; i++) begin
         exp_q.push_back(i == 0 ? 10 : 1);
         cyc(1'b1);
         want_err = (i > 255) ? 8'd255 : 8'(i);
         if (i >= 1) begin
            n_checks++;
            if (early !== 1'b1 || period !== 4'd1 || err_count !== want_err)
               $display("FAIL held_%0d got e=%0b p=%0d err=%0d want e=1 p=1 err=%0d",
                        i, early, period, err_count, want_err);
            else n_pass++;
         end
      end
      for (int i = 0; i < 11; i++) cyc(1'b0);
      n_checks++;
      if (missing !== 1'b1 || err_count !== 8'd255 || locked !== 1'b0)
         $display("FAIL held_sat_miss got m=%0b err=%0d l=%0b want m=1 err=255 l=0",
                  missing, err_count, locked);
      else n_pass++;
      check_drained("held");
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      miss_seen = 0;
      reset     = 1'b1;
      tick      = 1'b0;
      test_reset();
      test_lock_in();
      test_tolerance();
      test_early();
      test_missing();
      test_reset_mid();
      test_held_tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tick_monitor.md
# tick_monitor

Consumer-side checker for the periodic one-cycle tick strobe produced by the design's time base (FREQ_CLK/FREQ_WANTED divider). It measures the interval between consecutive ticks in `clk` cycles and reports it. It tracks lock to the expected rate through a three-state machine, and flags early and missing ticks. Game-logic blocks gate on `locked`; the debug path reads `period` and `err_count`.

## Interface
- `FREQ_CLK`, default 50000000: system clock frequency in Hz.
- `FREQ_WANTED`, default 20000: expected tick rate in Hz. NB_TIC = FREQ_CLK/FREQ_WANTED, integer division (2500 with defaults).
- `TOLERANCE`, default 2: allowed deviation from NB_TIC, in cycles, either side. Must be < NB_TIC.
- `LOCK_COUNT`, default 4: consecutive in-tolerance periods required to lock. Must be ≥ 1.
- W (derived): bit count of NB_TIC+TOLERANCE (12 with defaults).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `tick`, in, 1: tick strobe, synchronous to `clk`. Every high cycle counts as one tick; there is no edge detection.
- `period`, out, W: last measured interval, in cycles.
- `period_valid`, out, 1: one-cycle pulse when `period` updates.
- `locked`, out, 1: high while the state is LOCKED.
- `early`, out, 1: one-cycle pulse when a tick arrives with interval < NB_TIC-TOLERANCE.
- `missing`, out, 1: one-cycle pulse on timeout.
- `err_count`, out, 8: count of early plus missing events, saturating at 255.

## Operation
- Internal counter `cnt` (W bits) is cleared on every tick and otherwise increments. Interval P = `cnt`+1 on the tick cycle, so ticks at t0 and t0+2500 give P = 2500.
- A tick is good if NB_TIC-TOLERANCE ≤ P ≤ NB_TIC+TOLERANCE. It is early if P < NB_TIC-TOLERANCE.
- Timeout: in SYNC or LOCKED, `cnt` == NB_TIC+TOLERANCE-1 with no tick that cycle. A late tick therefore never exists: the timeout fires first.
- `good_cnt` counts consecutive good periods, 0..LOCK_COUNT.

States:
- IDLE: no reference tick yet. `cnt` holds at 0. Timeout is disabled.
  - tick → SYNC, `good_cnt`=0. No `period_valid` is generated.
- SYNC:
  - Good tick → `good_cnt`+1. When the incremented value reaches LOCK_COUNT → LOCKED.
  - Early tick → `good_cnt`=0, stay in SYNC, pulse `early`.
  - Timeout → IDLE, pulse `missing`.
- LOCKED:
  - Good tick → stay.
  - Early tick → SYNC, `good_cnt`=0, pulse `early`.
  - Timeout → IDLE, pulse `missing`.
- Every tick seen in SYNC or LOCKED, good or early, loads `period`=P and pulses `period_valid`.
- `err_count` increments on each `early` or `missing` pulse and holds at 255.
- `period` keeps its last value across IDLE. Only reset clears it.
- `tick` held high for n cycles in SYNC or LOCKED means n ticks. The second and later ones have P=1, which is early.

## Timing
- All outputs are registered.
- A tick at cycle t produces `period`, `period_valid`, `early` and the new `locked` at cycle t+1.
- Timeout latency: with the last tick at t0 and no further tick, `missing`=1 and `locked`=0 at t0+NB_TIC+TOLERANCE+1.
  - A tick at exactly t0+NB_TIC+TOLERANCE is good, and no `missing` is raised.
- `locked` rises at t+1, where t is the LOCK_COUNT-th consecutive good tick after the reference tick.
- Reset is synchronous, active-high, and takes priority over `tick`.
  - Applied at cycle t, including mid-LOCKED: state=IDLE, `cnt`=0, `good_cnt`=0.
  - At t+1: `period`=0, `period_valid`=0, `locked`=0, `early`=0, `missing`=0, `err_count`=0.
  - A tick present in the reset cycle is ignored.
- `early` and `missing` are mutually exclusive in any cycle. `err_count` therefore increments by at most 1 per cycle.

## Test plan
Bench parameters: FREQ_CLK=100, FREQ_WANTED=10 (NB_TIC=10), TOLERANCE=1, LOCK_COUNT=4, W=4.
- Lock-in: ticks every 10 cycles from t=5.
  - No `period_valid` after the tick at t=5.
  - `period`=10 with a `period_valid` pulse after each later tick.
  - `locked`=1 at t=46; `err_count`=0.
- Tolerance edges: while locked, intervals of 9 and then 11 → `period`=9, then 11; `locked` stays 1; no `early`, no `missing`.
- Early tick: while locked, a tick 8 cycles after the previous one.
  - Next cycle: `early`=1, `period`=8, `locked`=0, `err_count`=1.
  - Then four intervals of 10 → `locked`=1 again.
- Missing tick: while locked, ticks stop after t0.
  - `missing`=1 exactly at t0+12, `locked`=0, `err_count`+1.
  - The next tick produces no `period_valid`; the tick after that yields the measured interval.
- Reset mid-operation: reset for one cycle while locked with `err_count`=3.
  - All outputs are 0 the following cycle.
  - A tick coincident with reset is ignored.
- Saturation and held tick: hold `tick` high for 300 cycles after lock.
  - `early` pulses every cycle from the second high cycle on.
  - `period`=1 throughout.
  - `err_count` saturates at 255 and stays there.
